pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage pipeline: drives stall/flush of IF/ID, ID/EX,
//  EX/MEM and MEM/WB registers. Resolves load-use hazards, taken-branch redirects from EX and

---
 rtl/pipe_hazard_ctrl_pkg.sv | 15 +
 rtl/pipe_hazard_ctrl_if.sv | 51 +++++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 27 ++
 rtl/pipe_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Sequencer states, register-file address width and the x0 encoding.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERR
    } hz_state_t;

    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard sequencer bundle.
// master = pipeline datapath, slave = hazard sequencer.
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);

    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_mem_read;
    logic                  ex_branch_taken;
    logic                  mem_req;
    logic                  mem_ready;

    logic                  pc_write_en;
    logic                  stall_if;
    logic                  stall_id;
    logic                  stall_ex;
    logic                  stall_mem;
    logic                  flush_id;
    logic                  flush_ex;
    logic                  flush_mem;
    logic                  flush_wb;
    logic                  mem_timeout_err;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_events;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rd, ex_mem_read, ex_branch_taken,
        output mem_req, mem_ready,
        input  pc_write_en,
        input  stall_if, stall_id, stall_ex, stall_mem,
        input  flush_id, flush_ex, flush_mem, flush_wb,
        input  mem_timeout_err, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rd, ex_mem_read, ex_branch_taken,
        input  mem_req, mem_ready,
        output pc_write_en,
        output stall_if, stall_id, stall_ex, stall_mem,
        output flush_id, flush_ex, flush_mem, flush_wb,
        output mem_timeout_err, stall_cycles, flush_events
    );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use comparator: the load in EX targets a register that the instruction in ID reads.
// Writes to x0 never create a hazard.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int AW = REG_ADDR_W
) (
    input  logic [AW-1:0] id_rs1_i,
    input  logic [AW-1:0] id_rs2_i,
    input  logic          id_use_rs1_i,
    input  logic          id_use_rs2_i,
    input  logic [AW-1:0] ex_rd_i,
    input  logic          ex_mem_read_i,
    output logic          load_use_o
);

    logic rs1_hit;
    logic rs2_hit;
    logic rd_live;

    assign rs1_hit = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit = id_use_rs2_i && (id_rs2_i == ex_rd_i);
    assign rd_live = (ex_rd_i != AW'(REG_ZERO));

    assign load_use_o = ex_mem_read_i && rd_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (load-use, branch redirect, memory wait).
// Optional perf counters enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  bus
);

    import pipe_ctrl_pkg::*;

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_t       state_q;
    logic [WC_W-1:0] wait_cnt_q;
    logic            err_q;

    logic            load_use;
    logic            mem_hold;
    logic            pc_we;
    logic [3:0]      stall;
    logic [3:0]      flush;
    logic            br_flush;

    load_use_detect #(
        .AW (REG_ADDR_W)
    ) u_lud (
        .id_rs1_i      (bus.id_rs1),
        .id_rs2_i      (bus.id_rs2),
        .id_use_rs1_i  (bus.id_use_rs1),
        .id_use_rs2_i  (bus.id_use_rs2),
        .ex_rd_i       (bus.ex_rd),
        .ex_mem_read_i (bus.ex_mem_read),
        .load_use_o    (load_use)
    );

    assign mem_hold = bus.mem_req && !bus.mem_ready;

    // stall = {if,id,ex,mem}, flush = {id,ex,mem,wb}
    always_comb begin
        pc_we    = 1'b0;
        stall    = 4'b0000;
        flush    = 4'b0000;
        br_flush = 1'b0;
        if (!reset) begin
            unique case (state_q)
                RUN: begin
                    if (mem_hold) begin
                        stall = 4'b1111;
                        flush = 4'b0001;
                    end else if (bus.ex_branch_taken) begin
                        flush    = 4'b1100;
                        pc_we    = 1'b1;
                        br_flush = 1'b1;
                    end else if (load_use) begin
                        stall = 4'b1100;
                        flush = 4'b0100;
                    end else begin
                        pc_we = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    stall = 4'b1111;
                    flush = 4'b0001;
                end
                ERR: begin
                    stall = 4'b1111;
                    flush = 4'b1111;
                end
                default: begin
                    stall = 4'b0000;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (mem_hold) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= WC_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ready) begin
                        state_q    <= RUN;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WC_W'(MEM_TIMEOUT)) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WC_W'(1);
                    end
                end
                ERR: begin
                    err_q <= 1'b1;
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign bus.pc_write_en     = pc_we;
    assign bus.stall_if        = stall[3];
    assign bus.stall_id        = stall[2];
    assign bus.stall_ex        = stall[1];
    assign bus.stall_mem       = stall[0];
    assign bus.flush_id        = flush[3];
    assign bus.flush_ex        = flush[2];
    assign bus.flush_mem       = flush[1];
    assign bus.flush_wb        = flush[0];
    assign bus.mem_timeout_err = err_q;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall[3] && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (br_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall_cycles = stall_cnt_q;
    assign bus.flush_events = flush_cnt_q;
`else
    logic unused_br_flush;
    assign unused_br_flush  = br_flush;
    assign bus.stall_cycles = {CNT_W{1'b0}};
    assign bus.flush_events = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl against a cycle-level reference model.
// Counter expectations follow HAZ_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;
    localparam int TO = 4;
    localparam int CW = 4;

    // {pc_we, stall if/id/ex/mem, flush id/ex/mem/wb, err}
    localparam logic [9:0] P_RUN   = 10'b1_0000_0000_0;
    localparam logic [9:0] P_BR    = 10'b1_0000_1100_0;
    localparam logic [9:0] P_LU    = 10'b0_1100_0100_0;
    localparam logic [9:0] P_STALL = 10'b0_1111_0001_0;
    localparam logic [9:0] P_ERR   = 10'b0_1111_1111_1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(
        .REG_ADDR_W  (AW),
        .MEM_TIMEOUT (TO),
        .CNT_W       (CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: consecutive cycles the pipeline has been held on memory.
    int pend    = 0;
    bit m_err   = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    function automatic logic [9:0] obs();
        return {bus.pc_write_en, bus.stall_if, bus.stall_id, bus.stall_ex,
                bus.stall_mem, bus.flush_id, bus.flush_ex, bus.flush_mem,
                bus.flush_wb, bus.mem_timeout_err};
    endfunction

    function automatic logic [9:0] exp_ctrl();
        bit hit;
        if (reset) return 10'b0;
        if (m_err) return P_ERR;
        if (pend > 0 || (bus.mem_req && !bus.mem_ready)) return P_STALL;
        if (bus.ex_branch_taken) return P_BR;
        hit = bus.ex_mem_read && (bus.ex_rd != 0) &&
              ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
               (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
        if (hit) return P_LU;
        return P_RUN;
    endfunction

    function automatic int sat(input int v);
        int mx;
        mx = (1 << CW) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic int exp_sc();
`ifdef HAZ_PERF_CNT_EN
        return sat(m_stall);
`else
        return 0;
`endif
    endfunction

    function automatic int exp_fe();
`ifdef HAZ_PERF_CNT_EN
        return sat(m_flush);
`else
        return 0;
`endif
    endfunction

    task automatic clear_model();
        pend    = 0;
        m_err   = 1'b0;
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic drive(input int rs1, input int rs2, input int rd,
                         input bit u1, input bit u2, input bit mr,
                         input bit br, input bit rq, input bit rdy);
        bus.id_rs1          = AW'(rs1);
        bus.id_rs2          = AW'(rs2);
        bus.ex_rd           = AW'(rd);
        bus.id_use_rs1      = u1;
        bus.id_use_rs2      = u2;
        bus.ex_mem_read     = mr;
        bus.ex_branch_taken = br;
        bus.mem_req         = rq;
        bus.mem_ready       = rdy;
    endtask

    // Advance the model across one rising edge, then leave #1 for stimulus.
    task automatic tick(input logic [9:0] e);
        @(posedge clk);
        cyc++;
        if (!reset) begin
            if (e[8]) m_stall++;
            if (e == P_BR) m_flush++;
            if (!m_err) begin
                if ((pend > 0 || bus.mem_req) && !bus.mem_ready) begin
                    pend++;
                    if (pend > TO) m_err = 1'b1;
                end else if (pend > 0) begin
                    pend = 0;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_model();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [9:0] e;
        reset = 1'b1;
        clear_model();
        drive(5, 0, 5, 1, 0, 1, 1, 1, 0);
        @(negedge clk);
        e = exp_ctrl();
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=%b", obs(), e);
        end
        checks++;
        if (bus.stall_cycles !== CW'(0) || bus.flush_events !== CW'(0)) begin
            errors++;
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0",
                     bus.stall_cycles, bus.flush_events);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic test_load_use();
        logic [9:0] e;
        int tbl [5][9] = '{
            '{5, 0, 5, 1, 0, 1, 0, 0, 1},
            '{5, 0, 5, 1, 0, 0, 0, 0, 1},
            '{0, 0, 0, 1, 0, 1, 0, 0, 1},
            '{7, 5, 5, 0, 1, 1, 0, 0, 1},
            '{5, 0, 5, 1, 0, 1, 1, 0, 1}
        };
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3] != 0,
                  tbl[i][4] != 0, tbl[i][5] != 0, tbl[i][6] != 0,
                  tbl[i][7] != 0, tbl[i][8] != 0);
            @(negedge clk);
            e = exp_ctrl();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL load_use[%0d] got=%b exp=%b", i, obs(), e);
            end
            tick(e);
        end
    endtask

    task automatic test_mem_wait();
        logic [9:0] e;
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1, i < 4, i >= 3);
            @(negedge clk);
            e = exp_ctrl();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL mem_wait[%0d] got=%b exp=%b", i, obs(), e);
            end
            tick(e);
        end
    endtask

    task automatic test_timeout();
        logic [9:0] e;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, i >= 8);
            @(negedge clk);
            e = exp_ctrl();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL timeout[%0d] got=%b exp=%b", i, obs(), e);
            end
            tick(e);
        end
    endtask

    task automatic test_async_reset();
        logic [9:0] e;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            for (int i = 0; i < (k == 0 ? 2 : TO + 3); i++) begin
                drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
                @(negedge clk);
                e = exp_ctrl();
                tick(e);
            end
            #2;
            reset = 1'b1;
            clear_model();
            #1;
            e = exp_ctrl();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL async_reset[%0d] got=%b exp=%b", k, obs(), e);
            end
            @(posedge clk);
            #1;
            reset = 1'b0;
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
            @(negedge clk);
            e = exp_ctrl();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL after_reset[%0d] got=%b exp=%b", k, obs(), e);
            end
            tick(e);
        end
    endtask

    task automatic test_counters();
        logic [9:0] e;
        do_reset();
        for (int i = 0; i < 23; i++) begin
            if (i < 20) drive(5, 0, 5, 1, 0, 1, 0, 0, 1);
            else        drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
            @(negedge clk);
            e = exp_ctrl();
            checks++;
            if (bus.stall_cycles !== CW'(exp_sc()) ||
                bus.flush_events !== CW'(exp_fe())) begin
                errors++;
                $display("FAIL counters[%0d] got=%0d/%0d exp=%0d/%0d", i,
                         bus.stall_cycles, bus.flush_events, exp_sc(), exp_fe());
            end
            tick(e);
        end
        @(negedge clk);
        checks++;
        if (bus.stall_cycles !== CW'(exp_sc()) ||
            bus.flush_events !== CW'(exp_fe())) begin
            errors++;
            $display("FAIL counters_end got=%0d/%0d exp=%0d/%0d",
                     bus.stall_cycles, bus.flush_events, exp_sc(), exp_fe());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [9:0] e;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (m_err) do_reset();
            drive($urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 1) != 0,
                  $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) < 6);
            @(negedge clk);
            e = exp_ctrl();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL random[%0d] got=%b exp=%b", i, obs(), e);
            end
            checks++;
            if (bus.stall_cycles !== CW'(exp_sc()) ||
                bus.flush_events !== CW'(exp_fe())) begin
                errors++;
                $display("FAIL random_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i,
                         bus.stall_cycles, bus.flush_events, exp_sc(), exp_fe());
            end
            tick(e);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        test_reset();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        test_counters();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
